axi_mem_responder: RTL and testbench

AXI4 slave endpoint that terminates the bus with a flop-based memory, acting as the responder behind the pass-through slave adapter. It accepts FIXED, INCR and WRAP bursts on independent read and write channels and returns B/R responses with the requester's ID. It is used as a simulation and FPGA target for the interconnect and for adapter bring-up.

---
 rtl/axi_mem_responder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 slave terminating the bus in a flop-based memory.
// Independent read/write FSMs; FIXED/INCR/WRAP bursts; SLVERR on unsupported bursts.
module axi_mem_responder #(
  parameter int unsigned ID_WIDTH   = 10,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 6,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  // write address
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awregion,
  input  logic [3:0]              s_axi_awqos,
  input  logic [USER_WIDTH-1:0]   s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [USER_WIDTH-1:0]   s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // write response
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [USER_WIDTH-1:0]   s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // read address
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arregion,
  input  logic [3:0]              s_axi_arqos,
  input  logic [USER_WIDTH-1:0]   s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // read data
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [USER_WIDTH-1:0]   s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFFS_BITS  = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_BITS   = $clog2(MEM_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Unsupported size, reserved burst type, or WRAP with an illegal length.
  function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > 3'(OFFS_BITS)) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  // Address of the following beat; WRAP stays inside the (len+1)*2^size window.
  function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] nbytes, aligned, nxt, wmask;
    nbytes  = ADDR_WIDTH'(1) << size;
    aligned = addr & ~(nbytes - ADDR_WIDTH'(1));
    nxt     = aligned + nbytes;
    wmask   = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return addr;
      2'b10:   return (addr & ~wmask) | (nxt & wmask);
      default: return nxt;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  aw_err;
  logic                  wlast_err;
  logic [7:0]            w_cnt;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [IDX_BITS-1:0]   w_idx;
  logic                  w_last_beat;
  logic                  mem_we;

  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  ar_err;
  logic [7:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [IDX_BITS-1:0]   ar_in_idx;
  logic [IDX_BITS-1:0]   r_next_idx;
  logic                  ar_in_err;

  logic                  unused_ok;

  assign w_next_addr = step_addr(aw_addr, aw_len, aw_size, aw_burst);
  assign w_idx       = aw_addr[OFFS_BITS +: IDX_BITS];
  assign w_last_beat = (w_cnt == aw_len);
  assign mem_we      = s_axi_wready && s_axi_wvalid && !aw_err;

  assign r_next_addr = step_addr(ar_addr, ar_len, ar_size, ar_burst);
  assign r_next_idx  = r_next_addr[OFFS_BITS +: IDX_BITS];
  assign ar_in_idx   = s_axi_araddr[OFFS_BITS +: IDX_BITS];
  assign ar_in_err   = burst_err(s_axi_arlen, s_axi_arsize, s_axi_arburst);

  assign s_axi_buser = '0;
  assign s_axi_ruser = '0;

  assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awregion,
                       s_axi_awqos, s_axi_awuser, s_axi_wuser, s_axi_arlock,
                       s_axi_arcache, s_axi_arprot, s_axi_arregion, s_axi_arqos,
                       s_axi_aruser};

  // Byte-lane write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < int'(STRB_WIDTH); i++) begin
        if (s_axi_wstrb[i]) mem[w_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  // Write channel: AW -> data beats -> B.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= '0;
      aw_addr       <= '0;
      aw_len        <= '0;
      aw_size       <= '0;
      aw_burst      <= '0;
      aw_err        <= 1'b0;
      wlast_err     <= 1'b0;
      w_cnt         <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awready && s_axi_awvalid) begin
            s_axi_bid     <= s_axi_awid;
            aw_addr       <= s_axi_awaddr;
            aw_len        <= s_axi_awlen;
            aw_size       <= s_axi_awsize;
            aw_burst      <= s_axi_awburst;
            aw_err        <= burst_err(s_axi_awlen, s_axi_awsize, s_axi_awburst);
            wlast_err     <= 1'b0;
            w_cnt         <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            s_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid) begin
            aw_addr <= w_next_addr;
            w_cnt   <= w_cnt + 8'd1;
            if (w_last_beat) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (aw_err || wlast_err || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end else if (s_axi_wlast) begin
              wlast_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: AR -> beats; rdata is preloaded one beat ahead of the handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      ar_addr       <= '0;
      ar_len        <= '0;
      ar_size       <= '0;
      ar_burst      <= '0;
      ar_err        <= 1'b0;
      r_cnt         <= '0;
    end else if (r_state == R_IDLE) begin
      if (s_axi_arready && s_axi_arvalid) begin
        s_axi_rid     <= s_axi_arid;
        ar_addr       <= s_axi_araddr;
        ar_len        <= s_axi_arlen;
        ar_size       <= s_axi_arsize;
        ar_burst      <= s_axi_arburst;
        ar_err        <= ar_in_err;
        s_axi_rresp   <= ar_in_err ? RESP_SLVERR : RESP_OKAY;
        s_axi_rdata   <= ar_in_err ? '0 : mem[ar_in_idx];
        s_axi_rlast   <= (s_axi_arlen == 8'd0);
        r_cnt         <= '0;
        s_axi_arready <= 1'b0;
        s_axi_rvalid  <= 1'b1;
        r_state       <= R_DATA;
      end else begin
        s_axi_arready <= 1'b1;
      end
    end else if (s_axi_rready) begin
      if (s_axi_rlast) begin
        s_axi_rvalid  <= 1'b0;
        s_axi_rlast   <= 1'b0;
        s_axi_arready <= 1'b1;
        r_state       <= R_IDLE;
      end else begin
        ar_addr     <= r_next_addr;
        s_axi_rdata <= ar_err ? '0 : mem[r_next_idx];
        r_cnt       <= r_cnt + 8'd1;
        s_axi_rlast <= ((r_cnt + 8'd1) == ar_len);
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized self-checking bench for axi_mem_responder against a byte-level memory model.
module tb_axi_mem_responder;

  localparam int IDW   = 10;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int UW    = 6;
  localparam int WORDS = 1024;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic [IDW-1:0] s_axi_awid = '0;
  logic [AW-1:0]  s_axi_awaddr = '0;
  logic [7:0]     s_axi_awlen = '0;
  logic [2:0]     s_axi_awsize = '0;
  logic [1:0]     s_axi_awburst = '0;
  logic           s_axi_awlock = 1'b0;
  logic [3:0]     s_axi_awcache = '0;
  logic [2:0]     s_axi_awprot = '0;
  logic [3:0]     s_axi_awregion = '0;
  logic [3:0]     s_axi_awqos = '0;
  logic [UW-1:0]  s_axi_awuser = '0;
  logic           s_axi_awvalid = 1'b0;
  logic           s_axi_awready;
  logic [DW-1:0]  s_axi_wdata = '0;
  logic [DW/8-1:0] s_axi_wstrb = '0;
  logic           s_axi_wlast = 1'b0;
  logic [UW-1:0]  s_axi_wuser = '0;
  logic           s_axi_wvalid = 1'b0;
  logic           s_axi_wready;
  logic [IDW-1:0] s_axi_bid;
  logic [1:0]     s_axi_bresp;
  logic [UW-1:0]  s_axi_buser;
  logic           s_axi_bvalid;
  logic           s_axi_bready = 1'b0;
  logic [IDW-1:0] s_axi_arid = '0;
  logic [AW-1:0]  s_axi_araddr = '0;
  logic [7:0]     s_axi_arlen = '0;
  logic [2:0]     s_axi_arsize = '0;
  logic [1:0]     s_axi_arburst = '0;
  logic           s_axi_arlock = 1'b0;
  logic [3:0]     s_axi_arcache = '0;
  logic [2:0]     s_axi_arprot = '0;
  logic [3:0]     s_axi_arregion = '0;
  logic [3:0]     s_axi_arqos = '0;
  logic [UW-1:0]  s_axi_aruser = '0;
  logic           s_axi_arvalid = 1'b0;
  logic           s_axi_arready;
  logic [IDW-1:0] s_axi_rid;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast;
  logic [UW-1:0]  s_axi_ruser;
  logic           s_axi_rvalid;
  logic           s_axi_rready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [63:0] model [WORDS];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  axi_mem_responder dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awregion(s_axi_awregion),
    .s_axi_awqos(s_axi_awqos), .s_axi_awuser(s_axi_awuser), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wuser(s_axi_wuser), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arregion(s_axi_arregion),
    .s_axi_arqos(s_axi_arqos), .s_axi_aruser(s_axi_aruser), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [63:0] a);
    return int'((a >> 3) % 64'(WORDS));
  endfunction

  function automatic bit is_err(input int len, input int size, input int burst);
    return (size > 3) || (burst == 3) ||
           ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Byte address of beat i, from the burst-type definitions.
  function automatic logic [63:0] beat_addr(input logic [63:0] start, input int len,
                                            input int size, input int burst, input int i);
    logic [63:0] nb, al, total, base;
    nb = 64'(1) << size;
    al = start - (start % nb);
    if (burst == 0) return start;
    if (burst == 1) return (i == 0) ? start : al + 64'(i) * nb;
    total = 64'(len + 1) * nb;
    base  = start - (start % total);
    return base + ((al - base + 64'(i) * nb) % total);
  endfunction

  task automatic do_write(input logic [63:0] addr, input int len, input int size,
                          input int burst, input logic [9:0] id, input int bad_beat,
                          input bit gaps);
    bit err;
    logic [1:0] exp_resp;
    int n;
    int wi;
    err = is_err(len, size, burst);
    exp_resp = err ? 2'b10 : 2'b00;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = 3'(size); s_axi_awburst = 2'(burst); s_axi_awvalid = 1'b1;
    n = 0;
    while (s_axi_awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("aw_timeout", 64'd0, 64'd1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    chk("wready_after_aw", 64'(s_axi_wready), 64'd1);
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_axi_wvalid = 1'b0;
        @(negedge clk);
      end
      s_axi_wvalid = 1'b1; s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
      s_axi_wlast = ((i == len) != (i == bad_beat));
      if (i == bad_beat) exp_resp = 2'b10;
      n = 0;
      while (s_axi_wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("w_timeout", 64'd0, 64'd1);
      @(negedge clk);
      if (!err) begin
        wi = widx(beat_addr(addr, len, size, burst, i));
        for (int b = 0; b < 8; b++) if (ws[i][b]) model[wi][b*8 +: 8] = wd[i][b*8 +: 8];
      end
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    chk("bvalid", 64'(s_axi_bvalid), 64'd1);
    chk("bid", 64'(s_axi_bid), 64'(id));
    chk("bresp", 64'(s_axi_bresp), 64'(exp_resp));
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("bvalid_hold", 64'(s_axi_bvalid), 64'd1);
      chk("bresp_hold", 64'(s_axi_bresp), 64'(exp_resp));
    end
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    chk("awready_after_b", 64'(s_axi_awready), 64'd1);
    chk("bvalid_clear", 64'(s_axi_bvalid), 64'd0);
  endtask

  // mode: 0 always ready, 1 alternating, 2 random
  task automatic do_read(input logic [63:0] addr, input int len, input int size,
                         input int burst, input logic [9:0] id, input int mode);
    bit err;
    bit rdy;
    bit tog;
    int n;
    logic [63:0] exp;
    err = is_err(len, size, burst);
    tog = 1'b0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = 3'(size); s_axi_arburst = 2'(burst); s_axi_arvalid = 1'b1;
    n = 0;
    while (s_axi_arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ar_timeout", 64'd0, 64'd1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      exp = err ? 64'd0 : model[widx(beat_addr(addr, len, size, burst, i))];
      for (int c = 0; c < 20; c++) begin
        chk($sformatf("rvalid[%0d]", i), 64'(s_axi_rvalid), 64'd1);
        chk($sformatf("rdata[%0d]", i), s_axi_rdata, exp);
        chk($sformatf("rid[%0d]", i), 64'(s_axi_rid), 64'(id));
        chk($sformatf("rresp[%0d]", i), 64'(s_axi_rresp), err ? 64'd2 : 64'd0);
        chk($sformatf("rlast[%0d]", i), 64'(s_axi_rlast), (i == len) ? 64'd1 : 64'd0);
        tog = !tog;
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? !tog : 1'($urandom_range(0, 1));
        if (c == 19) rdy = 1'b1;
        s_axi_rready = rdy;
        @(negedge clk);
        if (rdy) break;
      end
    end
    s_axi_rready = 1'b0;
    chk("rvalid_clear", 64'(s_axi_rvalid), 64'd0);
    chk("arready_after_r", 64'(s_axi_arready), 64'd1);
  endtask

  task automatic rand_burst(input logic [63:0] lo, input logic [63:0] span, input bit alias_hi,
                            output logic [63:0] addr, output int len, output int size,
                            output int burst);
    int pick;
    size  = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
    burst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
    if (burst == 2) begin
      pick = int'($urandom_range(0, 4));
      len = (pick == 0) ? 1 : (pick == 1) ? 3 : (pick == 2) ? 7 : (pick == 3) ? 15 : 2;
    end else begin
      len = int'($urandom_range(0, 15));
    end
    addr = lo + 64'($urandom_range(0, int'(span) - 1));
    if (burst == 2 && size <= 3) addr = addr & ~((64'(1) << size) - 64'd1);
    if (alias_hi && $urandom_range(0, 3) == 0) addr = addr | (64'($urandom) << 13);
  endtask

  initial begin
    logic [63:0] a1, a2;
    int l1, z1, b1, l2, z2, b2;

    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(s_axi_awready), 64'd0);
    chk("rst_arready", 64'(s_axi_arready), 64'd0);
    chk("rst_wready", 64'(s_axi_wready), 64'd0);
    chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    chk("rst_rlast", 64'(s_axi_rlast), 64'd0);
    chk("rst_bid", 64'(s_axi_bid), 64'd0);
    chk("rst_rid", 64'(s_axi_rid), 64'd0);
    chk("rst_rdata", s_axi_rdata, 64'd0);
    chk("rst_bresp", 64'(s_axi_bresp), 64'd0);
    chk("rst_rresp", 64'(s_axi_rresp), 64'd0);
    rstn = 1'b1;
    chk("awready_pre_edge", 64'(s_axi_awready), 64'd0);
    @(negedge clk);
    chk("awready_first_edge", 64'(s_axi_awready), 64'd1);
    chk("arready_first_edge", 64'(s_axi_arready), 64'd1);

    // Fill the whole memory so every later read has a known expectation.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      do_write(64'(blk) * 64'h800, 255, 3, 1, 10'(blk), -1, 1'b0);
    end

    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    do_write(64'h40, 0, 3, 1, 10'h155, -1, 1'b0);
    do_read(64'h40, 0, 3, 1, 10'h2AA, 0);
    chk("single_word_model", model[8], 64'h1122334455667788);

    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    do_write(64'h100, 3, 3, 1, 10'h011, -1, 1'b0);
    do_read(64'h100, 3, 3, 1, 10'h012, 1);

    wd[0] = 64'hAAAA; wd[1] = 64'hBBBB; wd[2] = 64'hCCCC; wd[3] = 64'hDDDD;
    do_write(64'h100, 3, 3, 1, 10'h013, -1, 1'b1);
    do_read(64'h118, 3, 3, 2, 10'h014, 2);

    wd[0] = '1; ws[0] = 8'hFF;
    do_write(64'h200, 0, 3, 1, 10'h020, -1, 1'b0);
    wd[0] = 64'd0; ws[0] = 8'h0F;
    do_write(64'h200, 0, 3, 1, 10'h021, -1, 1'b0);
    do_read(64'h200, 0, 3, 1, 10'h022, 0);
    chk("partial_strobe_model", model[64], 64'hFFFFFFFF00000000);

    wd[0] = 64'h1; wd[1] = 64'h2; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(64'h300, 1, 4, 1, 10'h030, -1, 1'b0);
    do_read(64'h300, 1, 3, 1, 10'h031, 0);
    do_read(64'h300, 2, 3, 3, 10'h032, 2);

    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(64'h400, 3, 3, 1, 10'h040, 1, 1'b0);
    do_read(64'h400, 3, 3, 1, 10'h041, 0);

    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    fork
      do_write(64'h500, 3, 3, 1, 10'h050, -1, 1'b0);
      do_read(64'h600, 3, 3, 1, 10'h051, 0);
    join

    // Reset in the middle of an 8-beat write: first three beats land, the rest do not.
    for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    s_axi_awid = 10'h060; s_axi_awaddr = 64'h1000; s_axi_awlen = 8'd7;
    s_axi_awsize = 3'd3; s_axi_awburst = 2'd1; s_axi_awvalid = 1'b1;
    for (int n = 0; n < 50 && s_axi_awready !== 1'b1; n++) @(negedge clk);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wd[i]; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0;
      @(negedge clk);
      model[widx(64'h1000 + 64'(i) * 8)] = wd[i];
    end
    s_axi_wdata = wd[3];
    rstn = 1'b0;
    #1;
    chk("abort_awready", 64'(s_axi_awready), 64'd0);
    chk("abort_wready", 64'(s_axi_wready), 64'd0);
    chk("abort_bvalid", 64'(s_axi_bvalid), 64'd0);
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    rstn = 1'b1;
    chk("post_rst_awready_low", 64'(s_axi_awready), 64'd0);
    @(negedge clk);
    chk("post_rst_awready_high", 64'(s_axi_awready), 64'd1);
    chk("post_rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    do_read(64'h1000, 7, 3, 1, 10'h061, 0);

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = {$urandom, $urandom};
        ws[i] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      end
      if (t % 4 == 3) begin
        rand_burst(64'h0, 64'hF00, 1'b0, a1, l1, z1, b1);
        rand_burst(64'h1000, 64'hF00, 1'b0, a2, l2, z2, b2);
        fork
          do_write(a1, l1, z1, b1, 10'($urandom), -1, 1'b1);
          do_read(a2, l2, z2, b2, 10'($urandom), 2);
        join
      end else begin
        rand_burst(64'h0, 64'h2000, 1'b1, a1, l1, z1, b1);
        do_write(a1, l1, z1, b1, 10'($urandom),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, l1)) : -1, 1'b1);
        if ($urandom_range(0, 1) == 0) do_read(a1, l1, z1, b1, 10'($urandom), 2);
        else begin
          rand_burst(64'h0, 64'h2000, 1'b1, a2, l2, z2, b2);
          do_read(a2, l2, z2, b2, 10'($urandom), int'($urandom_range(0, 2)));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
